// File: rtl/ariane_pkg.sv
// rtl/ariane_pkg.sv - shared constants, config struct and FSM states for the event unit
package ariane_pkg;

  // Default number of counter slots, one per evu_mux instance
  localparam int unsigned NR_EVU_CNT_DEFAULT = 4;

  // Register address map
  localparam logic [3:0] EVU_ADDR_CNT0   = 4'h0;
  localparam logic [3:0] EVU_ADDR_CFG0   = 4'h4;
  localparam logic [3:0] EVU_ADDR_STATUS = 4'h8;
  localparam logic [3:0] EVU_ADDR_CTRL   = 4'h9;

  // Per-slot config register layout (bits[5:0] of the written word)
  typedef struct packed {
    logic       irq_en;
    logic       enable;
    logic [3:0] sel;
  } evu_cfg_t;

  // Controller states
  typedef enum logic [1:0] {
    EVU_IDLE  = 2'd0,
    EVU_RUN   = 2'd1,
    EVU_CLEAR = 2'd2
  } evu_state_e;

endpackage

// File: rtl/evu_cnt_slot.sv
// rtl/evu_cnt_slot.sv - one event counter slot: counter, config, sel-change blanking, overflow flag
module evu_cnt_slot
  import ariane_pkg::*;
#(
  parameter int unsigned CNT_W = 64
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             i_run,
  input  logic             i_clear,
  input  logic             i_debug_mode,
  input  logic             i_event,
  input  logic             i_cnt_we,
  input  logic             i_cfg_we,
  input  logic             i_sts_w1c,
  input  logic [CNT_W-1:0] i_wdata,
  output logic [CNT_W-1:0] o_cnt,
  output evu_cfg_t         o_cfg,
  output logic             o_sts
);

  logic [CNT_W-1:0] r_cnt;
  evu_cfg_t         r_cfg;
  logic [1:0]       r_blank;
  logic             r_sts;

  evu_cfg_t         w_cfg_new;
  logic             w_sel_change;
  logic             w_inc;
  logic             w_wrap;

  assign w_cfg_new    = evu_cfg_t'(i_wdata[5:0]);
  assign w_sel_change = i_cfg_we && (w_cfg_new.sel != r_cfg.sel);
  assign w_inc        = i_run && r_cfg.enable && i_event && !i_debug_mode && (r_blank == 2'd0);
  // A software write wins over the increment, so it also suppresses the wrap flag
  assign w_wrap       = w_inc && !i_cnt_we && (&r_cnt);

  // Counter: clear, then software load, then event increment (wraps naturally)
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_cnt_we) begin
      r_cnt <= i_wdata;
    end else if (w_inc) begin
      r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Config register; sel feeds the evu_mux straight from this flop
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cfg <= '0;
    end else if (i_cfg_we) begin
      r_cfg <= w_cfg_new;
    end
  end

  // Blank counting for two cycles after a sel change while the mux output settles
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_blank <= 2'd0;
    end else if (w_sel_change) begin
      r_blank <= 2'd2;
    end else if (r_blank != 2'd0) begin
      r_blank <= r_blank - 2'd1;
    end
  end

  // Overflow flag: W1C, but a same-edge overflow keeps it set
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_sts <= 1'b0;
    end else if (i_clear) begin
      r_sts <= 1'b0;
    end else begin
      r_sts <= (r_sts && !i_sts_w1c) || w_wrap;
    end
  end

  assign o_cnt = r_cnt;
  assign o_cfg = r_cfg;
  assign o_sts = r_sts;

endmodule

// File: rtl/evu_ctrl.sv
// rtl/evu_ctrl.sv - event unit controller: register port, run/clear FSM, counter slots, overflow irq
module evu_ctrl
  import ariane_pkg::*;
#(
  parameter int unsigned NR_EVU_CNT = NR_EVU_CNT_DEFAULT,
  parameter int unsigned CNT_W      = 64
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       cfg_req_i,
  input  logic                       cfg_we_i,
  input  logic [3:0]                 cfg_addr_i,
  input  logic [CNT_W-1:0]           cfg_wdata_i,
  output logic                       cfg_gnt_o,
  output logic                       cfg_rvalid_o,
  output logic [CNT_W-1:0]           cfg_rdata_o,
  output logic [NR_EVU_CNT-1:0][3:0] evu_sel_o,
  input  logic [NR_EVU_CNT-1:0]      evu_event_i,
  input  logic                       debug_mode_i,
  output logic                       ovf_irq_o
);

  evu_state_e       r_state;
  evu_state_e       w_state_next;
  logic             r_global_en;
  logic             r_rvalid;
  logic [CNT_W-1:0] r_rdata;
  logic             r_irq;

  logic             w_wr;
  logic             w_ctrl_we;
  logic             w_gen_next;
  logic             w_run;
  logic             w_clearing;
  logic [CNT_W-1:0] w_rdata;

  logic [NR_EVU_CNT-1:0] w_cnt_we;
  logic [NR_EVU_CNT-1:0] w_cfg_we;
  logic [NR_EVU_CNT-1:0] w_sts_w1c;
  logic [NR_EVU_CNT-1:0] w_sts;
  logic [NR_EVU_CNT-1:0] w_irq_en;
  logic [CNT_W-1:0]      w_cnt [NR_EVU_CNT];
  evu_cfg_t              w_cfg [NR_EVU_CNT];

  assign cfg_gnt_o  = cfg_req_i;
  assign w_wr       = cfg_req_i && cfg_we_i;
  assign w_ctrl_we  = w_wr && (cfg_addr_i == EVU_ADDR_CTRL);
  assign w_gen_next = w_ctrl_we ? cfg_wdata_i[0] : r_global_en;
  assign w_run      = (r_state == EVU_RUN);
  assign w_clearing = (r_state == EVU_CLEAR);

  // Global enable flop; clear_all is a strobe and is never stored
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_global_en <= 1'b0;
    end else if (w_ctrl_we) begin
      r_global_en <= cfg_wdata_i[0];
    end
  end

  // FSM state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= EVU_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state: follow global enable, one-cycle CLEAR on a clear_all write from any state
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      EVU_IDLE:  if (w_gen_next)  w_state_next = EVU_RUN;
      EVU_RUN:   if (!w_gen_next) w_state_next = EVU_IDLE;
      EVU_CLEAR: w_state_next = w_gen_next ? EVU_RUN : EVU_IDLE;
      default:   w_state_next = EVU_IDLE;
    endcase
    if (w_ctrl_we && cfg_wdata_i[1]) begin
      w_state_next = EVU_CLEAR;
    end
  end

  for (genvar g = 0; g < NR_EVU_CNT; g++) begin : g_slot
    assign w_cnt_we[g]  = w_wr && (g < 4) && (cfg_addr_i == EVU_ADDR_CNT0 + 4'(g));
    assign w_cfg_we[g]  = w_wr && (g < 4) && (cfg_addr_i == EVU_ADDR_CFG0 + 4'(g));
    assign w_sts_w1c[g] = w_wr && (cfg_addr_i == EVU_ADDR_STATUS) && cfg_wdata_i[g];
    assign w_irq_en[g]  = w_cfg[g].irq_en;
    assign evu_sel_o[g] = w_cfg[g].sel;

    evu_cnt_slot #(
      .CNT_W (CNT_W)
    ) u_slot (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .i_run        (w_run),
      .i_clear      (w_clearing),
      .i_debug_mode (debug_mode_i),
      .i_event      (evu_event_i[g]),
      .i_cnt_we     (w_cnt_we[g]),
      .i_cfg_we     (w_cfg_we[g]),
      .i_sts_w1c    (w_sts_w1c[g]),
      .i_wdata      (cfg_wdata_i),
      .o_cnt        (w_cnt[g]),
      .o_cfg        (w_cfg[g]),
      .o_sts        (w_sts[g])
    );
  end

  // Read data for the current access; writes and unmapped addresses return 0.
  // During CLEAR the counters and status already read as zero.
  always_comb begin
    w_rdata = '0;
    if (cfg_req_i && !cfg_we_i) begin
      for (int i = 0; i < int'(NR_EVU_CNT); i++) begin
        if (i < 4 && cfg_addr_i == EVU_ADDR_CNT0 + 4'(i)) w_rdata = w_clearing ? '0 : w_cnt[i];
        if (i < 4 && cfg_addr_i == EVU_ADDR_CFG0 + 4'(i)) w_rdata = CNT_W'(w_cfg[i]);
      end
      if (cfg_addr_i == EVU_ADDR_STATUS) w_rdata = w_clearing ? '0 : CNT_W'(w_sts);
      if (cfg_addr_i == EVU_ADDR_CTRL)   w_rdata = CNT_W'(r_global_en);
    end
  end

  // Response one cycle after every granted access; reset drops anything pending
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_rvalid <= cfg_req_i;
      r_rdata  <= w_rdata;
    end
  end

  // Interrupt registered from the current status and irq enables
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= |(w_sts & w_irq_en);
    end
  end

  assign cfg_rvalid_o = r_rvalid;
  assign cfg_rdata_o  = r_rdata;
  assign ovf_irq_o    = r_irq;

endmodule
